// File: rtl/msg_sched_pkg.sv
// Shared definitions for the SHA-2 message scheduler: width checks, sigma
// rotate/shift amounts for SHA-256 and SHA-512, round counts and FSM states.
package msg_sched_pkg;

  localparam int MSG_NUM_WORDS = 16;
  localparam int MSG_RND_W     = 7;

  // SHA-256 small sigmas
  localparam int R0A_32 = 7;
  localparam int R0B_32 = 18;
  localparam int S0_32  = 3;
  localparam int R1A_32 = 17;
  localparam int R1B_32 = 19;
  localparam int S1_32  = 10;

  // SHA-512 small sigmas
  localparam int R0A_64 = 1;
  localparam int R0B_64 = 8;
  localparam int S0_64  = 7;
  localparam int R1A_64 = 19;
  localparam int R1B_64 = 61;
  localparam int S1_64  = 6;

  function automatic bit word_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic int rounds_for_width(input int w);
    return (w == 64) ? 80 : 64;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/msg_sched_sigma.sv
// Combinational SHA-2 small sigma functions s0(x0_i) and s1(x1_i); the
// rotate/shift amounts follow WORD_W (32 = SHA-256, 64 = SHA-512).
module msg_sched_sigma
  import msg_sched_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x0_i,
  input  logic [WORD_W-1:0] x1_i,
  output logic [WORD_W-1:0] s0_o,
  output logic [WORD_W-1:0] s1_o
);

  localparam int R0A = (WORD_W == 64) ? R0A_64 : R0A_32;
  localparam int R0B = (WORD_W == 64) ? R0B_64 : R0B_32;
  localparam int S0  = (WORD_W == 64) ? S0_64  : S0_32;
  localparam int R1A = (WORD_W == 64) ? R1A_64 : R1A_32;
  localparam int R1B = (WORD_W == 64) ? R1B_64 : R1B_32;
  localparam int S1  = (WORD_W == 64) ? S1_64  : S1_32;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  assign s0_o = rotr(x0_i, R0A) ^ rotr(x0_i, R0B) ^ (x0_i >> S0);
  assign s1_o = rotr(x1_i, R1A) ^ rotr(x1_i, R1B) ^ (x1_i >> S1);

endmodule

// File: rtl/msg_sched_multi.sv
// SHA-2 message scheduler: loads a 16-word block, then streams W[0..N-1]
// over a valid/ready port. MSG_SCHED_PREFETCH_EN adds a one-block shadow
// so the next block can start with no bubble.
module msg_sched_multi
  import msg_sched_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = MSG_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WORDS*WORD_W-1:0] blk_data,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  input  logic                        abort,
  output logic [WORD_W-1:0]           w_data,
  output logic [MSG_RND_W-1:0]        w_round,
  output logic                        w_last,
  output logic                        w_valid,
  input  logic                        w_ready
);

  localparam int RND_W      = MSG_RND_W;
  localparam int NUM_ROUNDS = rounds_for_width(WORD_W);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  if (!word_w_legal(WORD_W) || NUM_WORDS != MSG_NUM_WORDS) begin : g_bad_cfg
    $error("msg_sched_multi: WORD_W must be 32 or 64 and NUM_WORDS must be 16");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds data stable while valid is high and ready is low;
  // ready may depend combinationally on abort and rst.

  state_t            state_q, state_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [WORD_W-1:0] window_q [NUM_WORDS];
  logic [WORD_W-1:0] window_d [NUM_WORDS];
  logic              load_en;
  logic [NUM_WORDS*WORD_W-1:0] load_src;
  logic [WORD_W-1:0] sig0, sig1;

`ifdef MSG_SCHED_PREFETCH_EN
  logic [NUM_WORDS*WORD_W-1:0] shadow_q, shadow_d;
  logic                        shadow_full_q, shadow_full_d;
`endif

  msg_sched_sigma #(.WORD_W(WORD_W)) u_sigma (
    .x0_i (window_q[1]),
    .x1_i (window_q[14]),
    .s0_o (sig0),
    .s1_o (sig1)
  );

  assign w_data  = window_q[0];
  assign w_round = round_q;
  assign w_last  = (state_q == RUN) && (round_q == LAST_RND);

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    window_d  = window_q;
    load_en   = 1'b0;
    load_src  = blk_data;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
`ifdef MSG_SCHED_PREFETCH_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MSG_SCHED_PREFETCH_EN
        blk_ready = !abort && !shadow_full_q && !rst;
        if (shadow_full_q && !abort) begin
          load_en       = 1'b1;
          load_src      = shadow_q;
          shadow_full_d = 1'b0;
          state_d       = RUN;
        end else if (blk_valid && blk_ready) begin
          load_en = 1'b1;
          state_d = RUN;
        end
`else
        blk_ready = !abort && !rst;
        if (blk_valid && blk_ready) begin
          load_en = 1'b1;
          state_d = RUN;
        end
`endif
      end

      RUN: begin
        w_valid = 1'b1;
`ifdef MSG_SCHED_PREFETCH_EN
        blk_ready = !abort && !shadow_full_q && !rst;
`endif
        if (abort) begin
          state_d = IDLE;
          round_d = '0;
`ifdef MSG_SCHED_PREFETCH_EN
          shadow_full_d = 1'b0;
`endif
        end else begin
`ifdef MSG_SCHED_PREFETCH_EN
          if (blk_valid && blk_ready) begin
            shadow_d      = blk_data;
            shadow_full_d = 1'b1;
          end
`endif
          if (w_ready) begin
            if (round_q == LAST_RND) begin
              round_d = '0;
`ifdef MSG_SCHED_PREFETCH_EN
              // A block arriving on the last-word cycle bypasses the shadow.
              if (shadow_full_q) begin
                load_en       = 1'b1;
                load_src      = shadow_q;
                shadow_full_d = 1'b0;
              end else if (blk_valid && blk_ready) begin
                load_en       = 1'b1;
                shadow_full_d = 1'b0;
              end else begin
                state_d = IDLE;
              end
`else
              state_d = IDLE;
`endif
            end else begin
              for (int k = 0; k < NUM_WORDS - 1; k++) begin
                window_d[k] = window_q[k+1];
              end
              window_d[NUM_WORDS-1] = sig1 + window_q[9] + sig0 + window_q[0];
              round_d = round_q + RND_W'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (load_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        window_d[i] = load_src[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
      end
      round_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        window_q[i] <= '0;
      end
`ifdef MSG_SCHED_PREFETCH_EN
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      window_q <= window_d;
`ifdef MSG_SCHED_PREFETCH_EN
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_msg_sched_multi.sv
// Bench for msg_sched_multi: a SHA-256 instance and a SHA-512 instance,
// checked against a schedule recurrence computed directly from W[t-2..t-16].
module tb_msg_sched_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [511:0] blk_data32;
  logic         blk_valid32, blk_ready32, abort32;
  logic [31:0]  w_data32;
  logic [6:0]   w_round32;
  logic         w_last32, w_valid32, w_ready32;

  logic [1023:0] blk_data64;
  logic          blk_valid64, blk_ready64, abort64;
  logic [63:0]   w_data64;
  logic [6:0]    w_round64;
  logic          w_last64, w_valid64, w_ready64;

  msg_sched_multi #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .blk_data(blk_data32), .blk_valid(blk_valid32),
    .blk_ready(blk_ready32), .abort(abort32), .w_data(w_data32),
    .w_round(w_round32), .w_last(w_last32), .w_valid(w_valid32), .w_ready(w_ready32)
  );

  msg_sched_multi #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .blk_data(blk_data64), .blk_valid(blk_valid64),
    .blk_ready(blk_ready64), .abort(abort64), .w_data(w_data64),
    .w_round(w_round64), .w_last(w_last64), .w_valid(w_valid64), .w_ready(w_ready64)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [63:0] ref_w [80];
  logic [31:0] got [64];

  function automatic logic [31:0] ss0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] ss0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] ss1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  function automatic void build_ref32(input logic [511:0] b);
    for (int t = 0; t < 16; t++) ref_w[t] = {32'h0, b[(15-t)*32 +: 32]};
    for (int t = 16; t < 64; t++)
      ref_w[t] = {32'h0, ss1_32(ref_w[t-2][31:0]) + ref_w[t-7][31:0]
                         + ss0_32(ref_w[t-15][31:0]) + ref_w[t-16][31:0]};
  endfunction

  function automatic void build_ref64(input logic [1023:0] b);
    for (int t = 0; t < 16; t++) ref_w[t] = b[(15-t)*64 +: 64];
    for (int t = 16; t < 80; t++)
      ref_w[t] = ss1_64(ref_w[t-2]) + ref_w[t-7] + ss0_64(ref_w[t-15]) + ref_w[t-16];
  endfunction

  function automatic void load_exp32();
    exp_q.delete();
    for (int t = 0; t < 64; t++) exp_q.push_back(ref_w[t][31:0]);
  endfunction

  function automatic logic [511:0] rand_blk32();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block32(input logic [511:0] b);
    bit ok;
    ok = 1'b0;
    blk_data32  = b;
    blk_valid32 = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (blk_ready32) ok = 1'b1;
      tick();
    end
    blk_valid32 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: blk_ready never seen, required 1");
    end
  endtask

  // Consumes words from exp_q; returns early (before the edge) when idx == stop_at.
  task automatic stream32(input bit stall, input int stop_at);
    int idx;
    bit prev_hold;
    logic [31:0] hd;
    logic [6:0] hr;
    logic hl;
    idx = 0;
    prev_hold = 1'b0;
    for (int c = 0; c < 2000 && idx < 64 && exp_q.size() > 0; c++) begin
      w_ready32 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checks++;
      if (w_valid32 !== 1'b1) begin
        errors++; $display("FAIL w_valid_run: got %b required 1 at word %0d", w_valid32, idx);
      end
      if (prev_hold) begin
        checks++;
        if ({w_data32, w_round32, w_last32} !== {hd, hr, hl}) begin
          errors++;
          $display("FAIL stall_stable: got %h/%0d/%b required %h/%0d/%b",
                   w_data32, w_round32, w_last32, hd, hr, hl);
        end
      end
      checks++;
      if (w_data32 !== exp_q[0]) begin
        errors++; $display("FAIL w_data[%0d]: got %h required %h", idx, w_data32, exp_q[0]);
      end
      checks++;
      if (w_round32 !== 7'(idx)) begin
        errors++; $display("FAIL w_round: got %0d required %0d", w_round32, idx);
      end
      checks++;
      if (w_last32 !== (idx == 63)) begin
        errors++; $display("FAIL w_last[%0d]: got %b required %b", idx, w_last32, (idx == 63));
      end
      if (idx == stop_at) return;
      prev_hold = !w_ready32;
      hd = w_data32; hr = w_round32; hl = w_last32;
      if (w_ready32) begin
        got[idx] = w_data32;
        void'(exp_q.pop_front());
        idx++;
      end
      tick();
    end
    checks++;
    if (idx < 64) begin
      errors++; $display("FAIL stream_timeout: got %0d words required 64", idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    blk_valid32 = 1'b0; abort32 = 1'b0; w_ready32 = 1'b0; blk_data32 = '0;
    blk_valid64 = 1'b0; abort64 = 1'b0; w_ready64 = 1'b0; blk_data64 = '0;
    tick(); tick();
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL rst_w_valid: got %b required 0", w_valid32); end
    checks++; if (w_last32 !== 1'b0) begin errors++; $display("FAIL rst_w_last: got %b required 0", w_last32); end
    checks++; if (w_round32 !== 7'd0) begin errors++; $display("FAIL rst_w_round: got %0d required 0", w_round32); end
    checks++; if (blk_ready32 !== 1'b0) begin errors++; $display("FAIL rst_blk_ready: got %b required 0", blk_ready32); end
    checks++; if (w_valid64 !== 1'b0) begin errors++; $display("FAIL rst_w_valid64: got %b required 0", w_valid64); end
    rst = 1'b0;
    #1;
    checks++; if (blk_ready32 !== 1'b1) begin errors++; $display("FAIL post_rst_blk_ready: got %b required 1", blk_ready32); end
    checks++; if (blk_ready64 !== 1'b1) begin errors++; $display("FAIL post_rst_blk_ready64: got %b required 1", blk_ready64); end
    tick();
  endtask

  task automatic test_abc();
    logic [511:0] b;
    b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    build_ref32(b);
    load_exp32();
    send_block32(b);
    stream32(1'b0, -1);
    #1;
    checks++; if (got[0]  !== 32'h61626380) begin errors++; $display("FAIL abc_W0: got %h required 61626380", got[0]); end
    checks++; if (got[15] !== 32'h00000018) begin errors++; $display("FAIL abc_W15: got %h required 00000018", got[15]); end
    checks++; if (got[16] !== 32'h61626380) begin errors++; $display("FAIL abc_W16: got %h required 61626380", got[16]); end
    checks++; if (got[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_W17: got %h required 000f0000", got[17]); end
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL abc_done_valid: got %b required 0", w_valid32); end
    checks++; if (blk_ready32 !== 1'b1) begin errors++; $display("FAIL abc_done_ready: got %b required 1", blk_ready32); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [511:0] b;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin
        b = '0; b[511:480] = 32'h61626380; b[31:0] = 32'h18;
      end else begin
        b = rand_blk32();
      end
      build_ref32(b);
      load_exp32();
      send_block32(b);
      stream32(1'b1, -1);
      w_ready32 = 1'b1;
      tick();
    end
  endtask

  task automatic test_sha512();
    logic [1023:0] b;
    int idx;
    for (int n = 0; n < 2; n++) begin
      b = '0;
      if (n == 0) b[1023:960] = 64'h1;
      else for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
      build_ref64(b);
      blk_data64 = b; blk_valid64 = 1'b1; w_ready64 = 1'b1;
      idx = 0;
      for (int c = 0; c < 200 && idx < 80; c++) begin
        #1;
        if (w_valid64) begin
          checks++;
          if (w_data64 !== ref_w[idx] || w_round64 !== 7'(idx) || w_last64 !== (idx == 79)) begin
            errors++;
            $display("FAIL sha512_word[%0d]: got %h/%0d/%b required %h/%0d/%b", idx,
                     w_data64, w_round64, w_last64, ref_w[idx], idx, (idx == 79));
          end
          if (n == 0 && idx == 16) begin
            checks++; if (w_data64 !== 64'h1) begin errors++; $display("FAIL sha512_W16: got %h required 1", w_data64); end
          end
          if (n == 0 && idx == 17) begin
            checks++; if (w_data64 !== 64'h0) begin errors++; $display("FAIL sha512_W17: got %h required 0", w_data64); end
          end
          if (n == 0 && idx == 18) begin
            checks++;
            if (w_data64 !== 64'h0000200000000008) begin
              errors++; $display("FAIL sha512_W18: got %h required 0000200000000008", w_data64);
            end
          end
          idx++;
        end
        if (blk_valid64 && blk_ready64) begin
          tick(); blk_valid64 = 1'b0;
        end else begin
          tick();
        end
      end
      #1;
      checks++; if (idx != 80) begin errors++; $display("FAIL sha512_count: got %0d required 80", idx); end
      checks++; if (w_valid64 !== 1'b0) begin errors++; $display("FAIL sha512_done: got %b required 0", w_valid64); end
      tick();
    end
    w_ready64 = 1'b0;
  endtask

  task automatic test_abort();
    logic [511:0] b;
    b = '0; b[511:480] = 32'h61626380; b[31:0] = 32'h18;
    build_ref32(b);
    load_exp32();
    send_block32(b);
    stream32(1'b0, 20);
    abort32 = 1'b1;
    tick();
    abort32 = 1'b0;
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b required 0", w_valid32); end
    checks++; if (blk_ready32 !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", blk_ready32); end
    abort32 = 1'b1;
    blk_valid32 = 1'b1;
    blk_data32 = rand_blk32();
    #1;
    checks++; if (blk_ready32 !== 1'b0) begin errors++; $display("FAIL idle_abort_ready: got %b required 0", blk_ready32); end
    tick();
    abort32 = 1'b0; blk_valid32 = 1'b0;
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL idle_abort_accept: got %b required 0", w_valid32); end
    b = rand_blk32();
    build_ref32(b);
    load_exp32();
    send_block32(b);
    stream32(1'b0, -1);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    b = rand_blk32();
    build_ref32(b);
    load_exp32();
    send_block32(b);
    stream32(1'b0, 30);
    rst = 1'b1;
    tick();
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", w_valid32); end
    checks++; if (w_round32 !== 7'd0) begin errors++; $display("FAIL midrst_round: got %0d required 0", w_round32); end
    checks++; if (blk_ready32 !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", blk_ready32); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (blk_ready32 !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b required 1", blk_ready32); end
    exp_q.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, b;
    int sent, consumed, gaps, br_viol;
    bit started;
    a = rand_blk32();
    b = rand_blk32();
    exp_q.delete();
    build_ref32(a);
    for (int t = 0; t < 64; t++) exp_q.push_back(ref_w[t][31:0]);
    build_ref32(b);
    for (int t = 0; t < 64; t++) exp_q.push_back(ref_w[t][31:0]);
    sent = 0; consumed = 0; gaps = 0; br_viol = 0; started = 1'b0;
    for (int c = 0; c < 400 && consumed < 128; c++) begin
      blk_valid32 = (sent < 2);
      blk_data32  = (sent == 0) ? a : b;
      w_ready32   = 1'b1;
      #1;
      if (w_valid32) begin
        started = 1'b1;
        checks++;
        if (w_data32 !== exp_q[0] || w_round32 !== 7'(consumed % 64)) begin
          errors++;
          $display("FAIL b2b_word[%0d]: got %h/%0d required %h/%0d", consumed,
                   w_data32, w_round32, exp_q[0], consumed % 64);
        end
`ifndef MSG_SCHED_PREFETCH_EN
        if (blk_ready32) br_viol++;
`endif
        void'(exp_q.pop_front());
        consumed++;
      end else if (started) begin
        gaps++;
      end
      if (blk_valid32 && blk_ready32) sent++;
      tick();
    end
    blk_valid32 = 1'b0;
    checks++; if (consumed != 128) begin errors++; $display("FAIL b2b_count: got %0d required 128", consumed); end
`ifdef MSG_SCHED_PREFETCH_EN
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d required 0", gaps); end
`else
    checks++; if (gaps < 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d required >=1", gaps); end
    checks++; if (br_viol != 0) begin errors++; $display("FAIL b2b_ready_in_run: got %0d required 0", br_viol); end
`endif
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b required 0", w_valid32); end
    tick();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_sha512();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
